// File: rtl/adpll_search_ctrl.sv
// adpll_search_ctrl: binary-search DCO acquisition, LSB tracking and lock detection.
// Define ADPLL_UNLOCK_DETECT_EN to enable loss-of-lock detection and re-acquisition.
module adpll_search_ctrl #(
    parameter int CODE_W      = 7,
    parameter int INIT_CODE   = 2 ** (CODE_W - 1),
    parameter int INIT_STEP   = 2 ** (CODE_W - 2),
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 8,
    parameter int RELOCK_STEP = 8
) (
    input  logic                   reset,
    input  logic                   phase_clk,
    input  logic                   p_up,
    input  logic                   p_down,
    output logic [CODE_W-1:0]      dco_code,
    output logic [2**CODE_W-1:0]   enable,
    output logic                   freq_lock,
    output logic                   polarity,
    output logic [1:0]             state
);
    localparam logic [1:0] SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
    localparam logic [1:0] D_NONE = 2'd0, D_UP = 2'd1, D_DN = 2'd2;

    if (LOCK_CNT < 1 || LOCK_CNT > 15 || UNLOCK_CNT < 1 || UNLOCK_CNT > 255 ||
        INIT_STEP < 2 || RELOCK_STEP < 2) begin : g_param_chk
        $error("adpll_search_ctrl: parameter out of range");
    end

    logic [CODE_W-1:0] step, step_n, step_half, mv_step, code_n, code_mv;
    logic [CODE_W:0]   sum_up, sum_dn;
    logic [1:0]        dir, last_dir, last_n, state_n;
    logic [3:0]        rev_cnt, rev_cnt_n, rev_inc;
    logic              mv, rev, search_done, lock_hit, unlock_hit, lock_n;

    assign dir = (!p_up && p_down) ? D_UP : (!p_down && p_up) ? D_DN : D_NONE;
    assign mv  = dir != D_NONE;
    assign rev = mv && last_dir != D_NONE && dir != last_dir;

    // Search halves the step before moving, so a reversal lands between the last two probes
    assign step_half = step >> 1;
    assign mv_step   = state == SEARCH ? (rev ? step_half : step) : CODE_W'(1);
    assign sum_up    = {1'b0, dco_code} + {1'b0, mv_step};
    assign sum_dn    = {1'b0, dco_code} - {1'b0, mv_step};
    assign code_mv   = dir == D_UP ? (sum_up[CODE_W] ? '1 : sum_up[CODE_W-1:0])
                                   : (sum_dn[CODE_W] ? '0 : sum_dn[CODE_W-1:0]);

    assign rev_inc     = rev_cnt + 4'd1;
    assign search_done = state == SEARCH && rev && step_half == CODE_W'(1);
    assign lock_hit    = state == TRACK && rev && rev_inc == 4'(LOCK_CNT);

`ifdef ADPLL_UNLOCK_DETECT_EN
    logic [7:0] run_cnt, run_inc;
    assign run_inc    = run_cnt + 8'd1;
    assign unlock_hit = state == LOCKED && mv && !rev && run_inc == 8'(UNLOCK_CNT);
    always_ff @(posedge reset or negedge phase_clk)
        if (reset)
            run_cnt <= '0;
        else if (mv && state == LOCKED)
            run_cnt <= (rev || unlock_hit) ? 8'd0 : run_inc;
`else
    assign unlock_hit = 1'b0;
`endif

    always_ff @(posedge reset or negedge phase_clk)
        if (reset) begin
            state     <= SEARCH;
            dco_code  <= CODE_W'(INIT_CODE);
            step      <= CODE_W'(INIT_STEP);
            last_dir  <= D_NONE;
            rev_cnt   <= '0;
            freq_lock <= 1'b0;
            polarity  <= 1'b0;
        end else begin
            state     <= state_n;
            dco_code  <= code_n;
            step      <= step_n;
            last_dir  <= last_n;
            rev_cnt   <= rev_cnt_n;
            freq_lock <= lock_n;
            polarity  <= rev;
        end

    always_comb begin
        state_n = !mv ? state : search_done ? TRACK : lock_hit ? LOCKED :
                  unlock_hit ? SEARCH : state;
    end

    always_comb begin
        code_n    = mv ? code_mv : dco_code;
        last_n    = mv ? dir : last_dir;
        step_n    = !mv ? step : unlock_hit ? CODE_W'(RELOCK_STEP) :
                    (state == SEARCH && rev) ? step_half : step;
        rev_cnt_n = !mv ? rev_cnt : state == TRACK ? (rev ? rev_inc : 4'd0) :
                    (search_done || unlock_hit) ? 4'd0 : rev_cnt;
        lock_n    = !mv ? freq_lock : lock_hit ? 1'b1 : unlock_hit ? 1'b0 : freq_lock;
    end

    for (genvar i = 0; i < 2 ** CODE_W; i++) begin : g_therm
        assign enable[i] = CODE_W'(i) < dco_code;
    end
endmodule

// File: tb/tb_adpll_search_ctrl.sv
// tb_adpll_search_ctrl: directed checks of search, tracking, lock, saturation and reset.
module tb_adpll_search_ctrl;
    logic         reset = 1'b1, phase_clk = 1'b1, p_up = 1'b1, p_down = 1'b1;
    logic [6:0]   dco_code;
    logic [127:0] enable;
    logic         freq_lock, polarity;
    logic [1:0]   state;
    int checks = 0, errors = 0;

    adpll_search_ctrl dut (
        .reset(reset), .phase_clk(phase_clk), .p_up(p_up), .p_down(p_down),
        .dco_code(dco_code), .enable(enable), .freq_lock(freq_lock),
        .polarity(polarity), .state(state)
    );

    always #5 phase_clk = ~phase_clk;

    function automatic logic [127:0] therm(input int c);
        logic [127:0] t = '0;
        for (int i = 0; i < 128; i++) t[i] = i < c;
        return t;
    endfunction

    // d: 0 = none (both high), 1 = up, 2 = down, 3 = none (both low)
    task automatic drive(input int d);
        @(posedge phase_clk);
        p_up   = !(d == 1 || d == 3);
        p_down = !(d == 2 || d == 3);
        @(negedge phase_clk);
        #2;
        p_up   = 1'b1;
        p_down = 1'b1;
    endtask

    task automatic do_reset;
        @(posedge phase_clk);
        p_up = 1'b1; p_down = 1'b1;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks += 5;
        if (dco_code !== 7'd64) begin errors++; $display("FAIL reset_code: got %0d expected 64", dco_code); end
        if (enable !== therm(64)) begin errors++; $display("FAIL reset_enable: got %h expected %h", enable, therm(64)); end
        if (freq_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", freq_lock); end
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (polarity !== 1'b0) begin errors++; $display("FAIL reset_pol: got %b expected 0", polarity); end
        @(posedge phase_clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_saturation;
        int exp_code[3] = '{96, 127, 127};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1);
            checks += 2;
            if (dco_code !== 7'(exp_code[i])) begin errors++; $display("FAIL sat_code[%0d]: got %0d expected %0d", i, dco_code, exp_code[i]); end
            if (polarity !== 1'b0) begin errors++; $display("FAIL sat_pol[%0d]: got %b expected 0", i, polarity); end
        end
        checks++;
        if (enable !== therm(127)) begin errors++; $display("FAIL sat_enable: got %h expected %h", enable, therm(127)); end
    endtask

    task automatic test_search;
        int dirs[6]  = '{2, 1, 2, 1, 2, 1};
        int codes[6] = '{32, 48, 40, 44, 42, 43};
        int pols[6]  = '{0, 1, 1, 1, 1, 1};
        int sts[6]   = '{0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(dirs[i]);
            checks += 3;
            if (dco_code !== 7'(codes[i])) begin errors++; $display("FAIL search_code[%0d]: got %0d expected %0d", i, dco_code, codes[i]); end
            if (polarity !== 1'(pols[i])) begin errors++; $display("FAIL search_pol[%0d]: got %b expected %0d", i, polarity, pols[i]); end
            if (state !== 2'(sts[i])) begin errors++; $display("FAIL search_state[%0d]: got %0d expected %0d", i, state, sts[i]); end
        end
        checks++;
        if (enable !== therm(43)) begin errors++; $display("FAIL search_enable: got %h expected %h", enable, therm(43)); end
    endtask

    task automatic test_lock;
        int dirs[4]  = '{2, 1, 2, 1};
        int codes[4] = '{42, 43, 42, 43};
        int sts[4]   = '{1, 1, 1, 2};
        int lks[4]   = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(dirs[i]);
            checks += 4;
            if (dco_code !== 7'(codes[i])) begin errors++; $display("FAIL lock_code[%0d]: got %0d expected %0d", i, dco_code, codes[i]); end
            if (state !== 2'(sts[i])) begin errors++; $display("FAIL lock_state[%0d]: got %0d expected %0d", i, state, sts[i]); end
            if (freq_lock !== 1'(lks[i])) begin errors++; $display("FAIL lock_flag[%0d]: got %b expected %0d", i, freq_lock, lks[i]); end
            if (polarity !== 1'b1) begin errors++; $display("FAIL lock_pol[%0d]: got %b expected 1", i, polarity); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(i % 2 == 0 ? 3 : 0);
            checks += 4;
            if (dco_code !== 7'd43) begin errors++; $display("FAIL none_code[%0d]: got %0d expected 43", i, dco_code); end
            if (state !== 2'd2) begin errors++; $display("FAIL none_state[%0d]: got %0d expected 2", i, state); end
            if (freq_lock !== 1'b1) begin errors++; $display("FAIL none_lock[%0d]: got %b expected 1", i, freq_lock); end
            if (polarity !== 1'b0) begin errors++; $display("FAIL none_pol[%0d]: got %b expected 0", i, polarity); end
        end
    endtask

    task automatic test_unlock;
        int exp_st, exp_lk, exp_next;
        for (int i = 0; i < 8; i++) begin
            drive(1);
`ifdef ADPLL_UNLOCK_DETECT_EN
            exp_st = i == 7 ? 0 : 2;
            exp_lk = i == 7 ? 0 : 1;
`else
            exp_st = 2;
            exp_lk = 1;
`endif
            checks += 4;
            if (dco_code !== 7'(44 + i)) begin errors++; $display("FAIL unlock_code[%0d]: got %0d expected %0d", i, dco_code, 44 + i); end
            if (state !== 2'(exp_st)) begin errors++; $display("FAIL unlock_state[%0d]: got %0d expected %0d", i, state, exp_st); end
            if (freq_lock !== 1'(exp_lk)) begin errors++; $display("FAIL unlock_flag[%0d]: got %b expected %0d", i, freq_lock, exp_lk); end
            if (polarity !== 1'b0) begin errors++; $display("FAIL unlock_pol[%0d]: got %b expected 0", i, polarity); end
        end
        drive(1);
`ifdef ADPLL_UNLOCK_DETECT_EN
        exp_next = 59; exp_st = 0;
`else
        exp_next = 52; exp_st = 2;
`endif
        checks += 2;
        if (dco_code !== 7'(exp_next)) begin errors++; $display("FAIL relock_code: got %0d expected %0d", dco_code, exp_next); end
        if (state !== 2'(exp_st)) begin errors++; $display("FAIL relock_state: got %0d expected %0d", state, exp_st); end
    endtask

    task automatic test_async_reset;
        int seq[10] = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
        do_reset();
        foreach (seq[i]) drive(seq[i]);
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL relocked_state: got %0d expected 2", state); end
        @(posedge phase_clk);
        #2 reset = 1'b1;
        #1;
        checks += 5;
        if (dco_code !== 7'd64) begin errors++; $display("FAIL async_code: got %0d expected 64", dco_code); end
        if (enable !== therm(64)) begin errors++; $display("FAIL async_enable: got %h expected %h", enable, therm(64)); end
        if (freq_lock !== 1'b0) begin errors++; $display("FAIL async_lock: got %b expected 0", freq_lock); end
        if (state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", state); end
        if (polarity !== 1'b0) begin errors++; $display("FAIL async_pol: got %b expected 0", polarity); end
        p_up = 1'b0;
        @(negedge phase_clk);
        #2;
        checks++;
        if (dco_code !== 7'd64) begin errors++; $display("FAIL held_code: got %0d expected 64", dco_code); end
        #1 reset = 1'b0;
        p_up = 1'b1;
        checks++;
        if (dco_code !== 7'd64) begin errors++; $display("FAIL release_code: got %0d expected 64", dco_code); end
        drive(2);
        checks += 3;
        if (dco_code !== 7'd32) begin errors++; $display("FAIL fresh_code: got %0d expected 32", dco_code); end
        if (polarity !== 1'b0) begin errors++; $display("FAIL fresh_pol: got %b expected 0", polarity); end
        if (state !== 2'd0) begin errors++; $display("FAIL fresh_state: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_search();
        test_lock();
        test_unlock();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
